// File: rtl/piso_shift_8.sv
// rtl/piso_shift_8.sv - parallel-in serial-out shifter with valid/ready load and frame-end marker
// Optional parity cycle after the data bits when PISO_PARITY_EN is defined.
module piso_shift_8 #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] D,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         last,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
  logic par_q;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t        state, state_next;
  logic [N-1:0]  shreg;
  logic [CW-1:0] cnt;
  logic          capture;
  logic          head;

  assign head = LSB_FIRST ? shreg[0] : shreg[N-1];

  // Outputs decode only registered state; load_valid affects only capture/next state.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    load_ready = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          capture    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        sout       = head;
        sout_valid = 1'b1;
        busy       = 1'b1;
        if (cnt == CNT_LAST) begin
`ifdef PISO_PARITY_EN
          state_next = PAR;
`else
          last       = 1'b1;
          load_ready = 1'b1;
          if (load_valid) begin
            capture = 1'b1;
          end else begin
            state_next = IDLE;
          end
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        sout       = par_q;
        sout_valid = 1'b1;
        busy       = 1'b1;
        last       = 1'b1;
        load_ready = 1'b1;
        if (load_valid) begin
          capture    = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
`ifdef PISO_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (capture) begin
        shreg <= D;
        cnt   <= '0;
`ifdef PISO_PARITY_EN
        par_q <= ^D;
`endif
      end else if (state == SHIFT) begin
        // Counter reaches N only while parked in PAR, never beyond.
        shreg <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_8.sv
// tb/tb_piso_shift_8.sv - scoreboard bench for piso_shift_8, MSB-first and LSB-first instances
module tb_piso_shift_8;

  localparam int N = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = N + 1;
`else
  localparam int FL = N;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] d   = '0;
  logic       lv  = 1'b0;
  logic       lr, so, sv, lst, bsy;
  logic [7:0] d2  = '0;
  logic       lv2 = 1'b0;
  logic       lr2, so2, sv2, lst2, bsy2;

  int errors = 0;
  int checks = 0;
  logic [1:0] q[$];
  logic [1:0] q2[$];

  always #5 clk = ~clk;

  piso_shift_8 #(.N(N), .LSB_FIRST(1'b0)) dut (
    .clk(clk), .clr(clr), .D(d), .load_valid(lv), .load_ready(lr),
    .sout(so), .sout_valid(sv), .last(lst), .busy(bsy)
  );

  piso_shift_8 #(.N(N), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .clr(clr), .D(d2), .load_valid(lv2), .load_ready(lr2),
    .sout(so2), .sout_valid(sv2), .last(lst2), .busy(bsy2)
  );

  // Expected {sout, last} per frame cycle, pushed when the word is offered.
  function automatic void push(input logic [7:0] w, input bit lsb);
    for (int i = 0; i < N; i++) begin
      logic b;
      logic l;
      b = lsb ? w[i] : w[N-1-i];
`ifdef PISO_PARITY_EN
      l = 1'b0;
`else
      l = (i == N - 1);
`endif
      if (lsb) q2.push_back({b, l});
      else     q.push_back({b, l});
    end
`ifdef PISO_PARITY_EN
    if (lsb) q2.push_back({^w, 1'b1});
    else     q.push_back({^w, 1'b1});
`endif
  endfunction

  task automatic test_reset();
    logic [1:0] e;
    #2;
    checks++;
    if ({so, sv, lst, bsy, lr} !== 5'b00001) begin
      errors++; $display("FAIL reset_idle got=%b required=00001", {so, sv, lst, bsy, lr});
    end
    @(negedge clk); clr = 1'b1;
    @(negedge clk); d = 8'h5A; lv = 1'b1;
    @(negedge clk); lv = 1'b0;
    @(negedge clk);
    checks++;
    if (sv !== 1'b1 || bsy !== 1'b1) begin
      errors++; $display("FAIL reset_midframe_active sv=%b busy=%b required 1 1", sv, bsy);
    end
    #2 clr = 1'b0;
    #1;
    checks++;
    if ({so, sv, lst, bsy} !== 4'b0000) begin
      errors++; $display("FAIL reset_async got=%b required=0000", {so, sv, lst, bsy});
    end
    @(negedge clk); clr = 1'b1;
    @(negedge clk); d = 8'h81; lv = 1'b1; push(8'h81, 1'b0);
    @(negedge clk); lv = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (i > 0) @(negedge clk);
      e = (q.size() > 0) ? q.pop_front() : 2'bxx;
      checks++;
      if (sv !== 1'b1 || {so, lst} !== e) begin
        errors++; $display("FAIL reset_frame81 cyc=%0d got=%b%b required=1%b", i, sv, {so, lst}, e);
      end
    end
  endtask

  task automatic test_single();
    logic [1:0] e;
    @(negedge clk); d = 8'hA5; lv = 1'b1; push(8'hA5, 1'b0);
    checks++;
    if (lr !== 1'b1) begin
      errors++; $display("FAIL single_ready_idle got=%b required=1", lr);
    end
    @(negedge clk); lv = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (sv !== 1'b1 || bsy !== 1'b1 || lr !== 1'(i == FL - 1)) begin
        errors++; $display("FAIL single_ctrl cyc=%0d sv=%b busy=%b ready=%b required 1 1 %0d", i, sv, bsy, lr, i == FL - 1);
      end
      e = (q.size() > 0) ? q.pop_front() : 2'bxx;
      checks++;
      if ({so, lst} !== e) begin
        errors++; $display("FAIL single_data cyc=%0d got=%b required=%b", i, {so, lst}, e);
      end
    end
    @(negedge clk);
    checks++;
    if (sv !== 1'b0 || bsy !== 1'b0 || lr !== 1'b1) begin
      errors++; $display("FAIL single_after sv=%b busy=%b ready=%b required 0 0 1", sv, bsy, lr);
    end
  endtask

  task automatic test_lsb_first();
    logic [1:0] e;
    logic [7:0] words [2];
    words[0] = 8'h01;
    words[1] = 8'h80;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk); d2 = words[w]; lv2 = 1'b1; push(words[w], 1'b1);
      @(negedge clk); lv2 = 1'b0;
      for (int i = 0; i < FL; i++) begin
        if (i > 0) @(negedge clk);
        e = (q2.size() > 0) ? q2.pop_front() : 2'bxx;
        checks++;
        if (sv2 !== 1'b1 || {so2, lst2} !== e) begin
          errors++; $display("FAIL lsb_%h cyc=%0d got=%b%b required=1%b", words[w], i, sv2, {so2, lst2}, e);
        end
      end
      @(negedge clk);
      checks++;
      if (sv2 !== 1'b0 || bsy2 !== 1'b0) begin
        errors++; $display("FAIL lsb_%h_after sv=%b busy=%b required 0 0", words[w], sv2, bsy2);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e;
    @(negedge clk); d = 8'hFF; lv = 1'b1; push(8'hFF, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 2 * FL; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (sv !== 1'b1 || bsy !== 1'b1 || lr !== 1'((i % FL) == FL - 1)) begin
        errors++; $display("FAIL b2b_ctrl cyc=%0d sv=%b busy=%b ready=%b required 1 1 %0d", i, sv, bsy, lr, (i % FL) == FL - 1);
      end
      e = (q.size() > 0) ? q.pop_front() : 2'bxx;
      checks++;
      if ({so, lst} !== e) begin
        errors++; $display("FAIL b2b_data cyc=%0d got=%b required=%b", i, {so, lst}, e);
      end
      if (i == FL - 1) begin
        d = 8'h00; push(8'h00, 1'b0);
      end
      if (i == FL) lv = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (sv !== 1'b0 || bsy !== 1'b0 || q.size() != 0) begin
      errors++; $display("FAIL b2b_end sv=%b busy=%b pending=%0d required 0 0 0", sv, bsy, q.size());
    end
  endtask

  task automatic test_mid_frame();
    logic [1:0] e;
    @(negedge clk); d = 8'h3C; lv = 1'b1; push(8'h3C, 1'b0);
    @(negedge clk); lv = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (i > 0) @(negedge clk);
      e = (q.size() > 0) ? q.pop_front() : 2'bxx;
      checks++;
      if (sv !== 1'b1 || {so, lst} !== e) begin
        errors++; $display("FAIL mid_data cyc=%0d got=%b%b required=1%b", i, sv, {so, lst}, e);
      end
      if (i == 3) begin
        d = 8'h00; lv = 1'b1;
        #1;
        checks++;
        if (lr !== 1'b0) begin
          errors++; $display("FAIL mid_ready got=%b required=0", lr);
        end
      end
      if (i == 4) lv = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (sv !== 1'b0 || bsy !== 1'b0) begin
        errors++; $display("FAIL mid_no_second cyc=%0d sv=%b busy=%b required 0 0", i, sv, bsy);
      end
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [1:0] e;
    logic [7:0] words [2];
    words[0] = 8'h07;
    words[1] = 8'h03;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk); d = words[w]; lv = 1'b1; push(words[w], 1'b0);
      @(negedge clk); lv = 1'b0;
      for (int i = 0; i < FL; i++) begin
        if (i > 0) @(negedge clk);
        e = (q.size() > 0) ? q.pop_front() : 2'bxx;
        checks++;
        if (sv !== 1'b1 || {so, lst} !== e) begin
          errors++; $display("FAIL parity_%h cyc=%0d got=%b%b required=1%b", words[w], i, sv, {so, lst}, e);
        end
      end
      @(negedge clk);
      checks++;
      if (sv !== 1'b0) begin
        errors++; $display("FAIL parity_%h_len sv=%b required=0", words[w], sv);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_lsb_first();
    test_back_to_back();
    test_mid_frame();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/piso_shift_8.md
Name: piso_shift_8

Overview:
- Parallel-in serial-out shift register. It is the unloading end of the team's 8-bit parallel register path.
- Accepts an N-bit word through a valid/ready load handshake and serialises it onto a single-bit output, one bit per clock.
- Each bit carries a valid strobe; a frame-end marker flags the final bit.
- Used wherever registered parallel data must leave over a one-wire serial link.

Parameters:
- N, 8: data word width; legal values 2 to 32.
- LSB_FIRST, 0: 0 sends the MSB first; 1 sends the LSB first.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-low.
- D  input  N  parallel word to transmit.
- load_valid  input  1  upstream asserts while D holds a word to send.
- load_ready  output  1  block can accept D at this edge.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a frame bit this cycle.
- last  output  1  current sout bit is the final bit of the frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset (clr low, asynchronous, any time including mid-frame):
  - state=IDLE, shift register=0, bit counter=0.
  - sout=0, sout_valid=0, last=0, busy=0, all immediately.
  - load_ready reads 1, but no capture occurs while clr is low.
- States: IDLE, SHIFT, plus PAR when the optional feature is compiled in.
- IDLE:
  - load_ready=1, busy=0, sout_valid=0, sout=0.
  - On a rising edge with load_valid=1: capture D into the shift register, set counter=0, go to SHIFT.
- SHIFT:
  - sout = the current head bit: D[N-1] first when LSB_FIRST=0, D[0] first when LSB_FIRST=1.
  - sout_valid=1 and busy=1.
  - Each edge shifts the next bit to the head and increments the counter.
  - last=1 when counter==N-1.
- Frame end, without parity, at counter==N-1:
  - load_ready=1 in this cycle, so back-to-back frames have no gap.
  - If load_valid=1 at that edge: capture the new D, reset the counter, stay in SHIFT.
  - Otherwise go to IDLE.
- Mid-frame load requests: load_ready=0 during SHIFT for every counter value other than the frame-end case above. load_valid is ignored and D is not sampled.
- Latency: word accepted at edge k → bit 0 of the frame on sout from edge k to edge k+1 → final bit from k+N-1 to k+N.
- Output timing: sout, sout_valid, last and busy decode only from registered state. There is no combinational path from D or load_valid to them.
- load_ready is a combinational decode of state and counter only.
- Counter width: ceil(log2(N+1)) bits. It never exceeds N.
- Upstream protocol rule: D must stay stable while load_valid=1 and load_ready=0. The block does not check this.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the N data bits, one extra cycle in state PAR.
  - In PAR: sout = even parity of the captured word (XOR of all N bits), sout_valid=1, busy=1.
  - last moves from the final data bit to the parity cycle.
  - load_ready's back-to-back window moves to the PAR cycle; load_ready=0 on the final data bit.
  - Frame length is N+1 cycles.
- Not defined: state PAR does not exist, frames are exactly N cycles, no parity logic is synthesised.

Test Plan:
- Reset:
  - Drive clr=0 mid-frame of 8'h5A → sout, sout_valid, last and busy go to 0 without waiting for a clock edge.
  - Release clr, then load 8'h81 → clean frame 1,0,0,0,0,0,0,1.
- Single frame, LSB_FIRST=0:
  - Load 8'hA5 at edge k → sout = 1,0,1,0,0,1,0,1 over cycles k..k+7.
  - sout_valid=1 on those 8 cycles; last=1 only on the eighth.
  - busy=0 and load_ready=1 afterwards.
- LSB_FIRST=1:
  - Load 8'h01 → sout = 1,0,0,0,0,0,0,0.
  - Load 8'h80 → sout = 0,0,0,0,0,0,0,1.
- Back-to-back:
  - Hold load_valid=1 with D=8'hFF, then switch D to 8'h00 at the first frame-end cycle.
  - Required: 16 contiguous sout_valid cycles, 8 ones then 8 zeros.
  - last is high on cycles 8 and 16; busy never drops.
- Mid-frame load request:
  - Pulse load_valid with D=8'h00 at bit 3 of an 8'h3C frame → load_ready=0 on that cycle.
  - Required: frame continues 0,0,1,1,1,1,0,0 unchanged; no second frame follows.
- PISO_PARITY_EN defined:
  - 8'h07 → 9-bit frame ending in parity 1, last on bit 9.
  - 8'h03 → parity bit 0.
  - Back-to-back load is accepted only on the parity cycle.
